// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_pkg
//  Description : Shared definitions for the multdiv unit. It holds the
//                multiplier FSM state encoding, the default operand width and
//                iteration count, and the radix-4 Booth select encoding with
//                its decode function.
//  Revision    : 1.0 - initial release
// ============================================================================
package multdiv_pkg;

    // Default operand/result width. It must be even because each iteration
    // retires two multiplier bits.
    localparam int MD_WIDTH = 32;
    localparam int MD_ITER  = MD_WIDTH / 2;

    // Multiplier control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // Booth partial-product selection
    typedef enum logic [2:0] {
        SEL_ZERO = 3'd0,   //  0
        SEL_PM   = 3'd1,   // +M
        SEL_P2M  = 3'd2,   // +2M
        SEL_NM   = 3'd3,   // -M
        SEL_N2M  = 3'd4    // -2M
    } booth_sel_e;

    // Recode one overlapping 3-bit multiplier window {b[i+1], b[i], b[i-1]}.
    function automatic booth_sel_e booth_decode(input logic [2:0] win);
        booth_sel_e sel;
        case (win)
            3'b001,
            3'b010:  sel = SEL_PM;
            3'b011:  sel = SEL_P2M;
            3'b100:  sel = SEL_N2M;
            3'b101,
            3'b110:  sel = SEL_NM;
            default: sel = SEL_ZERO;   // 000 and 111
        endcase
        return sel;
    endfunction

endpackage : multdiv_pkg
`default_nettype wire

// File: rtl/booth_mult_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : booth_mult_seq_if
//  Description : Handshake/data bundle between the execute stage (master) and
//                the sequential Booth multiplier (slave).
//  Ports       : ctrl_MULT      - start strobe (master -> slave)
//                data_operandA  - signed multiplicand (master -> slave)
//                data_operandB  - signed multiplier (master -> slave)
//                data_result    - low-word product (slave -> master)
//                data_exception - signed overflow of low word (slave -> master)
//                data_resultRDY - one-cycle result-valid pulse (slave -> master)
//                busy           - operation in progress (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface booth_mult_seq_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_MULT;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT,
        output data_operandA,
        output data_operandB,
        input  data_result,
        input  data_exception,
        input  data_resultRDY,
        input  busy
    );

    modport slave (
        input  ctrl_MULT,
        input  data_operandA,
        input  data_operandB,
        output data_result,
        output data_exception,
        output data_resultRDY,
        output busy
    );
endinterface : booth_mult_seq_if
`default_nettype wire

// File: rtl/booth_pp_sel.sv
`default_nettype none
// ============================================================================
//  Module      : booth_pp_sel
//  Description : Combinational radix-4 Booth partial-product selector. It
//                turns a 3-bit multiplier window into the signed addend
//                0, +M, +2M, -M or -2M. It holds no state.
//  Ports       : window_i - {b[i+1], b[i], b[i-1]} multiplier window
//                m_i      - multiplicand, already sign-extended to WIDTH+2
//                addend_o - selected addend, WIDTH+2 bits, two's complement
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_pp_sel
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  wire logic [2:0]       window_i,
    input  wire logic [WIDTH+1:0] m_i,
    output logic      [WIDTH+1:0] addend_o
);

    localparam int AW = WIDTH + 2;

    booth_sel_e      w_sel;
    logic [AW-1:0]   w_m2;

    // The two guard bits on M mean that 2M still fits without losing the sign.
    assign w_m2  = m_i << 1;
    assign w_sel = booth_decode(window_i);

    always_comb begin
        addend_o = '0;
        case (w_sel)
            SEL_PM:  addend_o = m_i;
            SEL_P2M: addend_o = w_m2;
            SEL_NM:  addend_o = -m_i;
            SEL_N2M: addend_o = -w_m2;
            default: addend_o = '0;
        endcase
    end

endmodule : booth_pp_sel
`default_nettype wire

// File: rtl/booth_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : booth_mult_seq
//  Description : Sequential signed multiplier that uses radix-4 (modified
//                Booth) recoding. It retires two multiplier bits per cycle,
//                so it takes WIDTH/2 iterations. It returns the registered
//                low-word product, a signed-overflow flag and a one-cycle
//                ready pulse.
//  Ports       : clock   - rising-edge clock
//                reset_n - asynchronous active-low reset
//                bus     - slave side of booth_mult_seq_if (start strobe,
//                          operands, result, exception, ready, busy)
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_mult_seq
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH     // must be even
) (
    input  wire logic          clock,
    input  wire logic          reset_n,
    booth_mult_seq_if.slave    bus
);

    localparam int ITER  = WIDTH / 2;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int AW    = WIDTH + 2;          // accumulator / multiplicand width
    localparam int PW    = 2 * WIDTH + 3;      // product register width

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(ITER - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [AW-1:0]      m_q,     m_d;
    logic [PW-1:0]      p_q,     p_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q,    exc_d;

    // ------------------------------------------------------------------
    // One Booth iteration
    // ------------------------------------------------------------------
    logic [AW-1:0]      w_addend;
    logic [AW-1:0]      w_sum;
    logic [PW-1:0]      w_p_add;
    logic [PW-1:0]      w_p_iter;
    logic [WIDTH-1:0]   w_hi;
    logic               w_ovf;

    booth_pp_sel #(
        .WIDTH    (WIDTH)
    ) u_pp_sel (
        .window_i (p_q[2:0]),
        .m_i      (m_q),
        .addend_o (w_addend)
    );

    // The upper AW bits accumulate modulo 2^AW. The whole register then shifts
    // right arithmetically by two, so the accumulator sign is replicated.
    assign w_sum    = p_q[PW-1:WIDTH+1] + w_addend;
    assign w_p_add  = {w_sum, p_q[WIDTH:0]};
    assign w_p_iter = $signed(w_p_add) >>> 2;

    // After the final iteration the 2*WIDTH-bit product sits at w_p_iter[2W:1].
    // Overflow: the high word is not a pure sign extension of the low word.
    assign w_hi  = w_p_iter[2*WIDTH:WIDTH+1];
    assign w_ovf = (w_hi != {WIDTH{w_p_iter[WIDTH]}});

    // ------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        m_d      = m_q;
        p_d      = p_q;
        result_d = result_q;
        exc_d    = exc_q;

        if (bus.ctrl_MULT) begin
            // A start in any state reloads the operation. In RUN this aborts
            // the old operation without a result update. In DONE the ready
            // pulse for the finished operation is still shown this cycle.
            m_d     = {{2{bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
            p_d     = {{AW{1'b0}}, bus.data_operandB, 1'b0};
            count_d = '0;
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    p_d     = w_p_iter;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == C_LAST) begin
                        state_d  = ST_DONE;
                        count_d  = '0;
                        result_d = w_p_iter[WIDTH:1];
                        exc_d    = w_ovf;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            m_q      <= '0;
            p_q      <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            m_q      <= m_d;
            p_q      <= p_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: every output is a register or a decode of the state register
    // ------------------------------------------------------------------
    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = (state_q == ST_DONE);
    assign bus.busy           = (state_q == ST_RUN);

endmodule : booth_mult_seq
`default_nettype wire

// File: tb/tb_booth_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_mult_seq
//  Description : Directed testbench for booth_mult_seq. It uses hand-computed
//                products, latency and pulse checks, abort, back-to-back and
//                mid-operation reset scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mult_seq;

    logic clock;
    logic reset_n;

    booth_mult_seq_if #(.WIDTH(32)) bus ();

    booth_mult_seq #(
        .WIDTH   (32)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present operands with the strobe for exactly one edge
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        tick();
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = 32'hDEAD_BEEF;   // operands need only be valid at start
        bus.data_operandB = 32'h0BAD_F00D;
    endtask

    // Called just after the start edge. Counts edges until ready and also
    // counts the busy-high samples seen before ready.
    task automatic wait_ready(output int n, output int nbusy);
        n     = 0;
        nbusy = 0;
        while (!bus.data_resultRDY && n < 40) begin
            if (bus.busy) nbusy++;
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic exp_e);
        int n, nbusy;
        start(a, b);
        wait_ready(n, nbusy);
        check({tag, "_latency"}, 64'(n), 64'd16);
        check({tag, "_busy_cycles"}, 64'(nbusy), 64'd16);
        check({tag, "_result"}, 64'(bus.data_result), 64'(exp_r));
        check({tag, "_exception"}, 64'(bus.data_exception), 64'(exp_e));
        tick();
        check({tag, "_rdy_one_cycle"}, 64'(bus.data_resultRDY), 64'd0);
    endtask

    initial begin : stim
        int n, nbusy, nrdy;

        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        reset_n           = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_result", 64'(bus.data_result), 64'd0);
        check("rst_exception", 64'(bus.data_exception), 64'd0);
        check("rst_rdy", 64'(bus.data_resultRDY), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        reset_n = 1'b1;
        tick();

        // Basic products and overflow boundaries
        run_op("mul_7x6",       32'd7,          32'd6,          32'h0000_002A, 1'b0);
        run_op("mul_m3x5",      32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1, 1'b0);
        run_op("mul_min_xm1",   32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1'b1);
        run_op("mul_max_x2",    32'h7FFF_FFFF,  32'd2,          32'hFFFF_FFFE, 1'b1);
        run_op("mul_hi_ovf",    32'hFFFF_0000,  32'h0001_0000,  32'h0000_0000, 1'b1);
        tick();
        tick();
        check("hold_result", 64'(bus.data_result), 64'd0);
        check("hold_exception", 64'(bus.data_exception), 64'd1);

        // Abort: restart at cycle 5 of a running operation
        start(32'd100, 32'd100);
        nrdy = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.data_resultRDY) nrdy++;
            tick();
        end
        start(32'd3, 32'd4);
        wait_ready(n, nbusy);
        check("abort_no_early_rdy", 64'(nrdy), 64'd0);
        check("abort_latency", 64'(n), 64'd16);
        check("abort_result", 64'(bus.data_result), 64'd12);
        check("abort_exception", 64'(bus.data_exception), 64'd0);
        tick();
        check("abort_rdy_one_cycle", 64'(bus.data_resultRDY), 64'd0);

        // Back-to-back: the new start is sampled during the DONE cycle
        start(32'd7, 32'd6);
        wait_ready(n, nbusy);
        check("b2b_first_latency", 64'(n), 64'd16);
        check("b2b_first_result", 64'(bus.data_result), 64'd42);
        start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("b2b_busy_after_restart", 64'(bus.busy), 64'd1);
        check("b2b_rdy_dropped", 64'(bus.data_resultRDY), 64'd0);
        check("b2b_result_held", 64'(bus.data_result), 64'd42);
        wait_ready(n, nbusy);
        check("b2b_second_latency", 64'(n), 64'd16);
        check("b2b_second_result", 64'(bus.data_result), 64'd1);
        check("b2b_second_exception", 64'(bus.data_exception), 64'd0);
        tick();

        // Reset asserted at cycle 8 of an operation
        start(32'd5, 32'd5);
        for (int i = 0; i < 7; i++) tick();
        reset_n = 1'b0;
        #1;
        check("mid_rst_result", 64'(bus.data_result), 64'd0);
        check("mid_rst_exception", 64'(bus.data_exception), 64'd0);
        check("mid_rst_rdy", 64'(bus.data_resultRDY), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        tick();
        reset_n = 1'b1;
        nrdy = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.data_resultRDY || bus.busy) nrdy++;
            tick();
        end
        check("post_rst_quiet", 64'(nrdy), 64'd0);
        run_op("post_rst_m7x9", 32'hFFFF_FFF9, 32'd9, 32'hFFFF_FFC1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_booth_mult_seq
`default_nettype wire

// File: doc/booth_mult_seq.md
# booth_mult_seq

Sequential signed multiplier for the processor's multdiv unit, using radix-4 (modified Booth) recoding. It retires 2 multiplier bits per cycle, so a full 32-bit product takes 16 iterations. The block accepts a one-cycle start strobe from the execute stage, runs its own internal iteration counter, and returns a registered low-word product with an overflow exception and a one-cycle ready pulse. The result is consumed by writeback through the multdiv result mux.

## Interface
- WIDTH, 32, operand/result width; must be even; ITER = WIDTH/2 iterations
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- ctrl_MULT  in  1  start strobe; sampled on a rising edge
- data_operandA  in  WIDTH  multiplicand, signed; sampled when ctrl_MULT=1
- data_operandB  in  WIDTH  multiplier, signed; sampled when ctrl_MULT=1
- data_result  out  WIDTH  low WIDTH bits of A*B; registered
- data_exception  out  1  signed overflow of the low-word result; registered
- data_resultRDY  out  1  high for exactly one cycle when a new result is valid
- busy  out  1  high while in RUN

## Operation
- States:
  - IDLE: waiting for ctrl_MULT.
  - RUN: iterating.
  - DONE: presenting the ready pulse.
- Reset (reset_n=0, immediate): state=IDLE, iteration count=0, product register=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0.
- IDLE, ctrl_MULT=1:
  - M <= A sign-extended to WIDTH+2 bits.
  - Product register P (2*WIDTH+3 bits) <= {(WIDTH+2)'b0, B, 1'b0}.
  - count <= 0; go to RUN.
- RUN, per cycle: recode P[2:0] as follows.
  - 000/111 -> 0
  - 001/010 -> +M
  - 011 -> +2M
  - 100 -> -2M
  - 101/110 -> -M
- RUN datapath: the upper WIDTH+2 bits of P receive the add/subtract, computed modulo 2^(WIDTH+2). Then P arithmetic-shifts right by 2 (sign replicated from the MSB).
- RUN, count: increments each cycle. On the cycle where count==ITER-1, go to DONE and update the output registers:
  - data_result <= 64-bit product bits [WIDTH-1:0].
  - data_exception <= 1 iff product bits [2*WIDTH-1:WIDTH] are not all equal to product bit [WIDTH-1].
- DONE: data_resultRDY=1 for this cycle only; next state is IDLE.
- ctrl_MULT while in RUN: abort the current operation, reload from the current operands, count=0, stay in RUN. The aborted operation produces no ready pulse and no result update.
- ctrl_MULT while in DONE: the ready pulse for the finished operation still occurs this cycle; the new operation loads and the next state is RUN.
- data_result and data_exception hold their value until the next completed operation.

## Timing
- Start sampled at edge E0. Iterations occur at edges E1..E16; the output registers update at E16. data_resultRDY is high between E16 and E17.
- Latency: 16 cycles for WIDTH=32 (ITER cycles in general) from the start edge to ready. Minimum issue interval is ITER+1 cycles; starting during DONE achieves back-to-back operation.
- Operands need only be valid on the start edge.
- No combinational path from inputs to outputs.
- Reset deasserting mid-operation leaves the block in IDLE; no spurious ready pulse.

## Structure
- Shared package `multdiv_pkg` holds:
  - state enum (IDLE, RUN, DONE)
  - WIDTH default and ITER
  - Booth select encoding (ZERO, PM, P2M, NM, N2M)
- One combinational sub-module, `booth_pp_sel`:
  - Inputs: 3-bit window and M.
  - Output: the WIDTH+2-bit signed addend (0, ±M, ±2M).
  - Contains no state.
- Top level holds the FSM, the iteration counter (width ceil(log2(ITER))), the P/M registers and the output registers.

## Test plan
- A=7, B=6, start -> data_resultRDY at exactly cycle 16 after the start edge, data_result=0x0000002A, data_exception=0, busy high cycles 1-16.
- A=-3, B=5 -> data_result=0xFFFFFFF1, data_exception=0; then A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, data_exception=1.
- A=0x7FFFFFFF, B=2 -> data_result=0xFFFFFFFE, data_exception=1; A=0xFFFF0000, B=0x00010000 -> data_result=0, data_exception=1.
- Abort case:
  - Stimulus: start 100*100, then pulse ctrl_MULT with A=3, B=4 at cycle 5.
  - Required: exactly one ready pulse, 16 cycles after the second start, data_result=12.
- Back-to-back case:
  - Stimulus: 7*6, then assert start with A=-1, B=-1 during the DONE cycle.
  - Required: ready with 42, then ready again 16 cycles later with data_result=1, data_exception=0.
- Reset case:
  - Stimulus: assert reset_n=0 at cycle 8 of an operation.
  - Required: all outputs are 0 immediately; no ready pulse after release; a new start gives a correct result.
